// File: rtl/cmp_pkg.sv
// Shared constants and types for the comparator operand-pair generator:
// requested-relation codes, one-hot {G,E,L} flags, FSM states and LFSR taps.
package cmp_pkg;

    localparam logic [1:0] REL_E   = 2'b00;
    localparam logic [1:0] REL_G   = 2'b01;
    localparam logic [1:0] REL_L   = 2'b10;
    localparam logic [1:0] REL_ANY = 2'b11;

    localparam logic [2:0] FLAG_G    = 3'b100;
    localparam logic [2:0] FLAG_E    = 3'b010;
    localparam logic [2:0] FLAG_L    = 3'b001;
    localparam logic [2:0] FLAG_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Maximal-length Galois taps for the supported LFSR widths (2*WIDTH).
    function automatic logic [31:0] lfsr_taps(input int unsigned lfsr_width);
        case (lfsr_width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/cmp_pair_gen_if.sv
// Request/response bundle of the operand-pair generator; the slave modport is
// the generator side, the master modport is the requester/consumer side.
interface cmp_pair_gen_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_rel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       rel;
    logic [15:0]      gen_cnt;

    modport master (
        output req_valid, req_rel, out_ready,
        input  req_ready, out_valid, a, b, rel, gen_cnt
    );

    modport slave (
        input  req_valid, req_rel, out_ready,
        output req_ready, out_valid, a, b, rel, gen_cnt
    );
endinterface

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with a parameterised tap mask; advances only
// while en is high.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = '0,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // The shifted-out bit feeds back into every tapped position.
            if (gi == WIDTH - 1) begin : g_top
                assign q_next[gi] = q_reg[0] & TAPS[gi];
            end else begin : g_mid
                assign q_next[gi] = q_reg[gi+1] ^ (q_reg[0] & TAPS[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= SEED;
        end else if (en) begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/cmp_pair_gen.sv
// Operand-pair generator: turns a requested relation into an (a, b) pair that
// satisfies it, drawn from an LFSR, with matching one-hot {G,E,L} flags.
module cmp_pair_gen
    import cmp_pkg::*;
#(
    parameter int                 WIDTH = 8,
    parameter logic [2*WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    cmp_pair_gen_if.slave  bus
);

    localparam int            LW   = 2 * WIDTH;
    localparam logic [LW-1:0] TAPS = LW'(lfsr_taps(LW));

    state_e           state_reg;
    logic [1:0]       req_rel_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       rel_reg;
    logic [15:0]      gen_cnt_reg;

    logic             lfsr_en;
    logic [LW-1:0]    lfsr_q;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] cand_a;
    logic [WIDTH-1:0] cand_b;
    logic [2:0]       cand_rel;
    logic             cand_ok;
    logic             req_ready_int;

    assign lfsr_en = (state_reg == GEN);

    lfsr_galois #(
        .WIDTH (LW),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    assign x  = lfsr_q[LW-1:WIDTH];
    assign y  = lfsr_q[WIDTH-1:0];
    assign hi = (x > y) ? x : y;
    assign lo = (x > y) ? y : x;

    // A strict relation cannot be built from equal halves; GEN then retries
    // on the next LFSR value.
    always_comb begin
        cand_a   = x;
        cand_b   = y;
        cand_rel = FLAG_NONE;
        cand_ok  = 1'b1;
        case (req_rel_reg)
            REL_E: begin
                cand_b   = x;
                cand_rel = FLAG_E;
            end
            REL_G: begin
                cand_a   = hi;
                cand_b   = lo;
                cand_rel = FLAG_G;
                cand_ok  = (x != y);
            end
            REL_L: begin
                cand_a   = lo;
                cand_b   = hi;
                cand_rel = FLAG_L;
                cand_ok  = (x != y);
            end
            default: begin
                cand_rel = (x > y) ? FLAG_G : ((x == y) ? FLAG_E : FLAG_L);
            end
        endcase
    end

    assign req_ready_int = (state_reg == IDLE) && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            req_rel_reg <= REL_E;
            a_reg       <= '0;
            b_reg       <= '0;
            rel_reg     <= FLAG_NONE;
            gen_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_int) begin
                        req_rel_reg <= bus.req_rel;
                        state_reg   <= GEN;
                    end
                end
                GEN: begin
                    if (cand_ok) begin
                        a_reg     <= cand_a;
                        b_reg     <= cand_b;
                        rel_reg   <= cand_rel;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        gen_cnt_reg <= gen_cnt_reg + 16'd1;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_int;
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.a         = a_reg;
    assign bus.b         = b_reg;
    assign bus.rel       = rel_reg;
    assign bus.gen_cnt   = gen_cnt_reg;

endmodule

// File: tb/tb_cmp_pair_gen.sv
// Self-checking bench for cmp_pair_gen: directed vector table, retry and
// backpressure sequences, reset in HOLD, and a 1000-request random mix.
module tb_cmp_pair_gen;

    typedef struct {
        logic [1:0] req;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] rel;
        int         lat;
    } vec_t;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int exp_cnt;
    int txn_no;

    logic [15:0] mdl_lfsr;
    vec_t        exp_q[$];
    vec_t        vecs[3];

    cmp_pair_gen_if #(.WIDTH(8)) bus1 ();
    cmp_pair_gen_if #(.WIDTH(8)) bus2 ();

    cmp_pair_gen #(.WIDTH(8), .SEED(16'hACE1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    cmp_pair_gen #(.WIDTH(8), .SEED(16'h5A5A)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [2:0] ref_rel(input logic [7:0] ra, input logic [7:0] rb);
        if (ra > rb)  return 3'b100;
        if (ra == rb) return 3'b010;
        return 3'b001;
    endfunction

    // Reference generator: walks the LFSR until the request can be met.
    task automatic model_gen(input logic [1:0] req, output vec_t e);
        logic [7:0] x;
        logic [7:0] y;
        bit         done;
        e.req = req; e.a = '0; e.b = '0; e.rel = '0; e.lat = 0;
        done = 1'b0;
        while (!done && e.lat < 1000) begin
            x = mdl_lfsr[15:8];
            y = mdl_lfsr[7:0];
            mdl_lfsr = lfsr_step(mdl_lfsr);
            e.lat++;
            case (req)
                2'b00: begin e.a = x; e.b = x; e.rel = 3'b010; done = 1'b1; end
                2'b01: if (x != y) begin
                    e.a = (x > y) ? x : y; e.b = (x > y) ? y : x; e.rel = 3'b100; done = 1'b1;
                end
                2'b10: if (x != y) begin
                    e.a = (x > y) ? y : x; e.b = (x > y) ? x : y; e.rel = 3'b001; done = 1'b1;
                end
                default: begin e.a = x; e.b = y; e.rel = ref_rel(x, y); done = 1'b1; end
            endcase
        end
    endtask

    // One request/response on dut1; expected record must already be queued.
    task automatic run_txn(input logic [1:0] req, input int stall, input bit pulse);
        vec_t       e;
        int         lat;
        logic [7:0] ha;
        logic [7:0] hb;
        logic [2:0] hr;
        chk("req_ready_idle", 32'(bus1.req_ready), 32'd1);
        bus1.req_valid = 1'b1;
        bus1.req_rel   = req;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        chk("out_valid_in_gen", 32'(bus1.out_valid), 32'd0);
        lat = 0;
        while (!bus1.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        if (!bus1.out_valid) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        chk("a", 32'(bus1.a), 32'(e.a));
        chk("b", 32'(bus1.b), 32'(e.b));
        chk("rel", 32'(bus1.rel), 32'(e.rel));
        chk("latency", 32'(lat), 32'(e.lat));
        chk("rel_vs_ab", 32'(bus1.rel), 32'(ref_rel(bus1.a, bus1.b)));
        ha = bus1.a; hb = bus1.b; hr = bus1.rel;
        for (int k = 0; k < stall; k++) begin
            if (pulse) bus1.req_valid = (k % 2 == 0);
            @(negedge clk);
            chk("hold_a", 32'(bus1.a), 32'(ha));
            chk("hold_b", 32'(bus1.b), 32'(hb));
            chk("hold_rel", 32'(bus1.rel), 32'(hr));
            chk("hold_valid", 32'(bus1.out_valid), 32'd1);
            chk("hold_req_ready", 32'(bus1.req_ready), 32'd0);
            chk("hold_gen_cnt", 32'(bus1.gen_cnt), 32'(exp_cnt));
        end
        bus1.req_valid = 1'b0;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        exp_cnt++;
        chk("out_valid_drop", 32'(bus1.out_valid), 32'd0);
        chk("gen_cnt", 32'(bus1.gen_cnt), 32'(exp_cnt & 16'hFFFF));
        txn_no++;
        $display("TXN %0d req=%0d a=%02h b=%02h rel=%03b lat=%0d cnt=%0d",
                 txn_no, req, ha, hb, hr, lat, bus1.gen_cnt);
    endtask

    task automatic run_table();
        vec_t scratch;
        for (int i = 0; i < 3; i++) begin
            model_gen(vecs[i].req, scratch);
            exp_q.push_back(vecs[i]);
            run_txn(vecs[i].req, 0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mdl_lfsr = 16'hACE1;
        exp_cnt  = 0;
    endtask

    initial begin
        vec_t e;
        int   lat;
        logic [1:0] rq;

        checks = 0; errors = 0; exp_cnt = 0; txn_no = 0;
        mdl_lfsr = 16'hACE1;
        vecs[0] = '{req: 2'b01, a: 8'hE1, b: 8'hAC, rel: 3'b100, lat: 1};
        vecs[1] = '{req: 2'b00, a: 8'hE2, b: 8'hE2, rel: 3'b010, lat: 1};
        vecs[2] = '{req: 2'b10, a: 8'h38, b: 8'h71, rel: 3'b001, lat: 1};

        bus1.req_valid = 1'b0; bus1.req_rel = 2'b00; bus1.out_ready = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_rel = 2'b00; bus2.out_ready = 1'b0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus1.req_ready), 32'd0);
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_a", 32'(bus1.a), 32'd0);
        chk("rst_b", 32'(bus1.b), 32'd0);
        chk("rst_rel", 32'(bus1.rel), 32'd0);
        chk("rst_gen_cnt", 32'(bus1.gen_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed G, E, L from the default seed
        run_table();
        chk("gen_cnt_after_table", 32'(bus1.gen_cnt), 32'd3);

        // Seed 5A5A: two retries before a G pair appears
        bus2.req_valid = 1'b1;
        bus2.req_rel   = 2'b01;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat = 0;
        while (!bus2.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("retry_latency", 32'(lat), 32'd3);
        chk("retry_a", 32'(bus2.a), 32'h0000_00A2);
        chk("retry_b", 32'(bus2.b), 32'h0000_0096);
        chk("retry_rel", 32'(bus2.rel), 32'd4);
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        chk("retry_gen_cnt", 32'(bus2.gen_cnt), 32'd1);

        // Backpressure for 10 cycles with req_valid pulses that must be ignored
        model_gen(2'b11, e);
        exp_q.push_back(e);
        run_txn(2'b11, 10, 1'b1);
        model_gen(2'b01, e);
        exp_q.push_back(e);
        run_txn(2'b01, 0, 1'b0);

        // Reset while in HOLD
        bus1.req_rel = 2'b01;
        bus1.req_valid = 1'b1;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_before_reset", 32'(bus1.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("mid_rst_a", 32'(bus1.a), 32'd0);
        chk("mid_rst_b", 32'(bus1.b), 32'd0);
        chk("mid_rst_rel", 32'(bus1.rel), 32'd0);
        chk("mid_rst_gen_cnt", 32'(bus1.gen_cnt), 32'd0);
        chk("mid_rst_req_ready", 32'(bus1.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mdl_lfsr = 16'hACE1;
        exp_cnt  = 0;
        run_table();

        // Random mix of 1000 requests
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            rq = 2'($urandom_range(0, 3));
            model_gen(rq, e);
            exp_q.push_back(e);
            run_txn(rq, int'($urandom_range(0, 2)), 1'b0);
        end
        chk("gen_cnt_1000", 32'(bus1.gen_cnt), 32'd1000);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_pair_gen.md
# cmp_pair_gen

Operand-pair generator that closes the loop around the team's magnitude comparators. A requester asks for a relation (greater, equal, less, or any), and the block emits an N-bit pair (a, b) that satisfies it, together with the matching one-hot {G,E,L} flags. The pair comes from an internal Galois LFSR, and the block uses valid/ready handshakes on both sides. It sits in front of comparator datapaths as a self-checking stimulus source and as a pseudo-random operand engine.

## Interface
- WIDTH, 8: operand width; legal values are 4, 8 and 16.
- SEED, 16'hACE1: LFSR reset value, 2*WIDTH bits wide; must be nonzero.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state==IDLE) && rst_n.
- req_rel  in  2  requested relation: 00 = E (a==b), 01 = G (a>b), 10 = L (a<b), 11 = ANY.
- out_valid  out  1  pair available.
- out_ready  in  1  consumer accepts the pair.
- a  out  WIDTH  first operand.
- b  out  WIDTH  second operand.
- rel  out  3  one-hot {G,E,L} for the emitted (a, b); always consistent with a and b.
- gen_cnt  out  16  count of completed output handshakes; wraps at 16'hFFFF.

## Operation
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_rel and go to GEN.
  - GEN: evaluate the current LFSR value and either finish or retry (see below).
  - HOLD: out_valid=1. On out_ready, go to IDLE and increment gen_cnt.
- LFSR, lfsr[2W-1:0], Galois right-shift:
  - next = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
  - TAPS: 8'hB8 (W=4), 16'hB400 (W=8), 32'h80200003 (W=16).
  - Advances on every GEN-state edge and only then.
- Candidates: x = lfsr[2W-1:W], y = lfsr[W-1:0].
- GEN rules:
  - E: a=b=x; always succeeds.
  - G: a=max(x,y), b=min(x,y).
  - L: a=min(x,y), b=max(x,y).
  - ANY: a=x, b=y; always succeeds.
  - G or L with x==y: retry. Stay in GEN; the LFSR has advanced, so the next cycle evaluates a fresh value.
- On success: register a, b and rel, then go to HOLD.
- rel encoding: G=3'b100, E=3'b010, L=3'b001.
- Comparison is unsigned.
- a, b and rel hold stable from entry into HOLD until the handshake completes; they keep their last values in IDLE.
- Simultaneous events:
  - out_ready while out_valid=0 is ignored.
  - req_valid outside IDLE is not accepted (req_ready=0).
- Reset mid-operation:
  - Any pending request or output is dropped.
  - State→IDLE, lfsr→SEED, out_valid=0, a=b=0, rel=0, gen_cnt=0.

## Timing
- Reset values: req_ready=0 while rst_n=0 (1 once released), out_valid=0, a=0, b=0, rel=3'b000, gen_cnt=0.
- Accept at edge T0; out_valid rises at edge T1 when there is no retry. Each retry adds one cycle.
- Retries are bounded because the LFSR is maximal-length over 2W bits.
- Throughput: one pair per 3 cycles minimum (IDLE, GEN, HOLD), plus one cycle per retry.
- gen_cnt updates on the same edge that clears out_valid.
- No combinational path from req_valid to out_valid, or from out_ready to req_ready. req_ready is a decode of registered state only.

## Structure
- Package cmp_pkg holds:
  - rel code localparams (REL_E, REL_G, REL_L, REL_ANY);
  - one-hot flag constants;
  - the state enum (IDLE, GEN, HOLD);
  - a function returning TAPS for a given 2*WIDTH.
- Sub-module lfsr_galois:
  - parameters: width, taps, seed;
  - ports: clk, rst_n, en, q.
- The top holds the FSM, the max/min select, the output registers and gen_cnt.

## Test plan
- W=8, SEED=16'hACE1, request G → after one GEN cycle: a=8'hE1, b=8'hAC, rel=3'b100; lfsr becomes 16'hE270.
- Follow-up request E → a=b=8'hE2, rel=3'b010. Then request L → a=8'h38, b=8'h71, rel=3'b001; gen_cnt=3.
- SEED=16'h5A5A, request G → two retries (candidates 5A/5A, then 2D/2D), three GEN cycles total; output a=8'hA2, b=8'h96, rel=3'b100.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises → a, b and rel stable, req_ready=0, and req_valid pulses are not accepted. Release → exactly one handshake and gen_cnt increments by 1.
- Assert rst_n=0 while in HOLD → out_valid=0 and a=b=0 immediately; after release, the same request sequence reproduces the first scenario.
- Random mix of 1000 requests, including ANY, checked against a reference comparator → rel always matches (a,b); G/L/E requests always satisfied; gen_cnt=1000.
